// File: rtl/ht_preamble_seq_pkg.sv
// ht_preamble_seq_pkg: state encoding, ROM geometry and HT-LTF count normalisation
// shared by the HT preamble sequencer and its output register.
package openofdm_tx_pre_def;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STF    = 3'd1;
  localparam logic [2:0] S_LTF_CP = 3'd2;
  localparam logic [2:0] S_LTF    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam int STF_PERIOD    = 16;
  localparam int LTF_ROM_DEPTH = 64;
  // 0 -> 1, 1 -> 1, 2 -> 2, anything above 2 -> 4
  function automatic logic [2:0] norm_ltf(input logic [2:0] n);
    return (n <= 3'd2) ? ((n == 3'd0) ? 3'd1 : n) : 3'd4;
  endfunction
endpackage

// File: rtl/ht_preamble_seq_outreg.sv
// ht_preamble_outreg: 32-bit valid/ready holding register with a last flag.
// Ports: i_clk, i_rst_n (async, active low), i_clr (sync flush), i_load (capture i_din/i_last),
//        i_ready (downstream accept), o_q/o_valid/o_last (held sample).
module ht_preamble_outreg (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic        i_ready,
  input  logic        i_last,
  input  logic [31:0] i_din,
  output logic [31:0] o_q,
  output logic        o_valid,
  output logic        o_last
);
  logic [31:0] r_q;
  logic        r_valid;
  logic        r_last;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q     <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_q     <= i_din;
      r_valid <= 1'b1;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end
  assign o_q     = r_q;
  assign o_valid = r_valid;
  assign o_last  = r_last;
endmodule

// File: rtl/ht_preamble_seq.sv
// ht_preamble_seq: sequences HT-STF then nltf x (HT-LTF CP + body) from external ROMs into a valid/ready stream.
// Ports: clk, phy_tx_arestn (async, active low), start/abort/num_ltf (control),
//        stf_addr/stf_dout and ltf_addr/ltf_dout (combinational ROMs),
//        out_iq/out_valid/out_ready/out_last (sample stream), busy, done (pulse after last accept).
module ht_preamble_seq
  import openofdm_tx_pre_def::*;
#(
  parameter int STF_REPS   = 5,
  parameter int LTF_CP_LEN = 16,
  parameter int LTF_LEN    = 64
) (
  input  logic        clk,
  input  logic        phy_tx_arestn,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  num_ltf,
  output logic [3:0]  stf_addr,
  input  logic [31:0] stf_dout,
  output logic [5:0]  ltf_addr,
  input  logic [31:0] ltf_dout,
  output logic [31:0] out_iq,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);
  localparam int STF_LEN = STF_PERIOD * STF_REPS;
  localparam int CW      = $clog2(STF_LEN > LTF_LEN ? STF_LEN : LTF_LEN);
  logic [2:0]    r_state;
  logic [2:0]    w_nstate;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sym;
  logic [2:0]    r_nltf;
  logic          r_done;
  logic          w_adv;
  logic          w_acc;
  logic          w_load;
  logic          w_stf_end;
  logic          w_cp_end;
  logic          w_ltf_end;
  logic          w_sym_end;
  logic          w_field_end;
  logic          w_last_in;
  logic [31:0]   w_din;
  assign w_adv       = !out_valid || out_ready;
  assign w_acc       = out_valid && out_ready;
  assign w_stf_end   = r_cnt == CW'(STF_LEN - 1);
  assign w_cp_end    = r_cnt == CW'(LTF_CP_LEN - 1);
  assign w_ltf_end   = r_cnt == CW'(LTF_LEN - 1);
  assign w_sym_end   = {1'b0, r_sym} == r_nltf - 3'd1;
  assign w_field_end = r_state == S_STF ? w_stf_end : r_state == S_LTF_CP ? w_cp_end : w_ltf_end;
  // a sample is fetched only when the output register can take it, so ROM addresses hold during stalls
  assign w_load      = w_adv && !abort && (r_state == S_STF || r_state == S_LTF_CP || r_state == S_LTF);
  always_ff @(posedge clk or negedge phy_tx_arestn) begin
    if (!phy_tx_arestn) r_state <= S_IDLE;
    else r_state <= w_nstate;
  end
  always_comb begin
    w_nstate = r_state;
    if (abort) w_nstate = S_IDLE;
    else case (r_state)
      S_IDLE:   w_nstate = start ? S_STF : S_IDLE;
      S_STF:    w_nstate = (w_load && w_stf_end) ? S_LTF_CP : S_STF;
      S_LTF_CP: w_nstate = (w_load && w_cp_end) ? S_LTF : S_LTF_CP;
      S_LTF:    w_nstate = (w_load && w_ltf_end) ? (w_sym_end ? S_DRAIN : S_LTF_CP) : S_LTF;
      S_DRAIN:  w_nstate = w_acc ? S_IDLE : S_DRAIN;
      default:  w_nstate = S_IDLE;
    endcase
  end
  always_comb begin
    stf_addr  = r_state == S_STF ? r_cnt[3:0] : '0;
    ltf_addr  = r_state == S_LTF_CP ? 6'(LTF_LEN - LTF_CP_LEN) + r_cnt[5:0] : r_state == S_LTF ? r_cnt[5:0] : '0;
    w_din     = r_state == S_STF ? stf_dout : ltf_dout;
    w_last_in = r_state == S_LTF && w_ltf_end && w_sym_end;
    busy      = r_state != S_IDLE;
  end
  always_ff @(posedge clk or negedge phy_tx_arestn) begin
    if (!phy_tx_arestn) begin
      r_cnt  <= '0;
      r_sym  <= '0;
      r_nltf <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= !abort && r_state == S_DRAIN && w_acc;
      if (abort || r_state == S_IDLE) begin
        r_cnt <= '0;
        r_sym <= '0;
        if (r_state == S_IDLE && start && !abort) r_nltf <= norm_ltf(num_ltf);
      end else if (w_load) begin
        r_cnt <= w_field_end ? '0 : r_cnt + 1'b1;
        if (r_state == S_LTF && w_ltf_end && !w_sym_end) r_sym <= r_sym + 1'b1;
      end
    end
  end
  assign done = r_done;
  ht_preamble_outreg u_outreg (
    .i_clk   (clk),
    .i_rst_n (phy_tx_arestn),
    .i_clr   (abort),
    .i_load  (w_load),
    .i_ready (out_ready),
    .i_last  (w_last_in),
    .i_din   (w_din),
    .o_q     (out_iq),
    .o_valid (out_valid),
    .o_last  (out_last)
  );
endmodule

// File: tb/tb_ht_preamble_seq.sv
// tb_ht_preamble_seq: randomized self-checking bench for ht_preamble_seq against a field-level sample model.
module tb_ht_preamble_seq;
  logic        clk;
  logic        phy_tx_arestn;
  logic        start;
  logic        abort;
  logic [2:0]  num_ltf;
  logic [3:0]  stf_addr;
  logic [31:0] stf_dout;
  logic [5:0]  ltf_addr;
  logic [31:0] ltf_dout;
  logic [31:0] out_iq;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [31:0] stf_rom [16];
  logic [31:0] ltf_rom [64];
  int checks = 0;
  int failures = 0;
  logic [31:0] got [$];
  logic [31:0] exp_q [$];
  logic [31:0] ref_q [$];
  int  last_hits, last_pos, done_cnt, done_gap, unstable, first_valid_cyc;
  bit  timed_out;
  logic first_busy, post_busy, post_valid;

  ht_preamble_seq dut (
    .clk           (clk),
    .phy_tx_arestn (phy_tx_arestn),
    .start         (start),
    .abort         (abort),
    .num_ltf       (num_ltf),
    .stf_addr      (stf_addr),
    .stf_dout      (stf_dout),
    .ltf_addr      (ltf_addr),
    .ltf_dout      (ltf_dout),
    .out_iq        (out_iq),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done)
  );

  assign stf_dout = stf_rom[stf_addr];
  assign ltf_dout = ltf_rom[ltf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 80 STF samples (16-sample period repeated), then per LTF symbol the last 16 body samples as CP plus the 64-sample body.
  task automatic build_exp(input logic [2:0] n);
    int nl;
    nl = (n == 0) ? 1 : (n <= 2) ? int'(n) : 4;
    exp_q.delete();
    for (int i = 0; i < 80; i++) exp_q.push_back(stf_rom[i % 16]);
    for (int s = 0; s < nl; s++) begin
      for (int k = 48; k < 64; k++) exp_q.push_back(ltf_rom[k]);
      for (int k = 0; k < 64; k++) exp_q.push_back(ltf_rom[k]);
    end
  endtask

  function automatic int seq_diff(input logic [31:0] a [$], input logic [31:0] b [$]);
    int d;
    d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) d++;
    return d;
  endfunction

  // Pulses start, then drives out_ready per cycle and records every accepted sample until done (or abort/timeout).
  task automatic run(input logic [2:0] n, input int stall_pct, input int abort_at, input int repulse_at);
    int cyc, acc_last;
    logic pv, pr;
    logic [31:0] piq;
    logic [3:0] psa;
    logic [5:0] pla;
    bit stop;
    got.delete();
    last_hits = 0; last_pos = -1; done_cnt = 0; done_gap = -1; unstable = 0; first_valid_cyc = -1;
    timed_out = 0; post_busy = 1'b1; post_valid = 1'b1; first_busy = 1'b0;
    @(negedge clk);
    num_ltf = n; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    pv = 1'b0; pr = 1'b0; piq = '0; psa = '0; pla = '0; stop = 0; acc_last = -100;
    for (cyc = 0; cyc < 3000 && !stop; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = (cyc == repulse_at);
      if (cyc == 0) first_busy = busy;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pv && !pr && (out_iq !== piq || stf_addr !== psa || ltf_addr !== pla)) unstable++;
      if (done) begin
        done_cnt++;
        done_gap = cyc - acc_last;
        stop = 1;
      end else if (abort_at >= 0 && got.size() == abort_at) begin
        abort = 1'b1; out_ready = 1'b0; start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        post_busy = busy; post_valid = out_valid;
        repeat (6) begin
          if (done) done_cnt++;
          @(negedge clk);
        end
        stop = 1;
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
        if (out_valid && out_ready) begin
          got.push_back(out_iq);
          if (out_last) begin
            last_hits++;
            last_pos = got.size() - 1;
            acc_last = cyc;
          end
        end
        pv = out_valid; pr = out_ready; piq = out_iq; psa = stf_addr; pla = ltf_addr;
      end
    end
    if (!stop) timed_out = 1;
    start = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    phy_tx_arestn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; num_ltf = 3'd1;
    #12;
    checks++;
    if ({out_iq, out_valid, out_last, busy, done, stf_addr, ltf_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: iq=%h valid=%b last=%b busy=%b done=%b sa=%h la=%h, required all 0",
               out_iq, out_valid, out_last, busy, done, stf_addr, ltf_addr);
    end
    @(negedge clk);
    phy_tx_arestn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b valid=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_single_ltf();
    run(3'd1, 0, -1, -1);
    build_exp(3'd1);
    checks++;
    if (timed_out) begin failures++; $display("FAIL single_timeout: no done within budget, got %0d samples", got.size()); end
    checks++;
    if (first_busy !== 1'b1) begin failures++; $display("FAIL single_busy_rise: busy=%b, required 1", first_busy); end
    checks++;
    if (first_valid_cyc != 1) begin failures++; $display("FAIL single_latency: first valid at cycle %0d, required 1", first_valid_cyc); end
    checks++;
    if (got[0] !== 32'h061C061C) begin failures++; $display("FAIL sample0: got %h, required 061c061c", got[0]); end
    checks++;
    if (got[1] !== 32'hEE680050) begin failures++; $display("FAIL sample1: got %h, required ee680050", got[1]); end
    checks++;
    if (got[16] !== stf_rom[0]) begin failures++; $display("FAIL sample16: got %h, required %h", got[16], stf_rom[0]); end
    checks++;
    if (got[80] !== ltf_rom[48]) begin failures++; $display("FAIL sample80: got %h, required %h", got[80], ltf_rom[48]); end
    checks++;
    if (got[96] !== ltf_rom[0]) begin failures++; $display("FAIL sample96: got %h, required %h", got[96], ltf_rom[0]); end
    checks++;
    if (seq_diff(got, exp_q) != 0) begin
      failures++;
      $display("FAIL single_seq: %0d samples with %0d differences, required %0d samples and 0", got.size(), seq_diff(got, exp_q), exp_q.size());
    end
    checks++;
    if (last_hits != 1 || last_pos != 159) begin
      failures++;
      $display("FAIL single_last: %0d last flags at index %0d, required 1 at 159", last_hits, last_pos);
    end
    checks++;
    if (done_cnt != 1 || done_gap != 1) begin
      failures++;
      $display("FAIL single_done: %0d pulses, gap %0d cycles, required 1 pulse gap 1", done_cnt, done_gap);
    end
  endtask

  task automatic test_multi_ltf();
    logic [2:0] ns [2] = '{3'd2, 3'd4};
    int sizes [2] = '{240, 400};
    for (int t = 0; t < 2; t++) begin
      run(ns[t], 0, -1, -1);
      build_exp(ns[t]);
      checks++;
      if (got.size() != sizes[t] || seq_diff(got, exp_q) != 0) begin
        failures++;
        $display("FAIL multi_seq n=%0d: %0d samples with %0d differences, required %0d and 0", ns[t], got.size(), seq_diff(got, exp_q), sizes[t]);
      end
      checks++;
      if (last_hits != 1 || last_pos != sizes[t] - 1 || done_cnt != 1) begin
        failures++;
        $display("FAIL multi_last n=%0d: %0d last flags at %0d, done %0d, required 1 at %0d, done 1", ns[t], last_hits, last_pos, done_cnt, sizes[t] - 1);
      end
    end
  endtask

  task automatic test_stall();
    run(3'd2, 0, -1, -1);
    ref_q = got;
    run(3'd2, 40, -1, -1);
    checks++;
    if (timed_out || seq_diff(got, ref_q) != 0) begin
      failures++;
      $display("FAIL stall_seq: %0d samples with %0d differences (timeout %0d), required %0d and 0", got.size(), seq_diff(got, ref_q), timed_out, ref_q.size());
    end
    checks++;
    if (unstable != 0) begin failures++; $display("FAIL stall_hold: %0d stalled cycles changed iq/addr, required 0", unstable); end
    checks++;
    if (last_hits != 1 || last_pos != 239 || done_gap != 1) begin
      failures++;
      $display("FAIL stall_last: %0d last at %0d, done gap %0d, required 1 at 239 gap 1", last_hits, last_pos, done_gap);
    end
  endtask

  task automatic test_abort();
    logic [31:0] head [$];
    run(3'd2, 0, 100, -1);
    build_exp(3'd2);
    for (int i = 0; i < 100; i++) head.push_back(exp_q[i]);
    checks++;
    if (post_busy !== 1'b0 || post_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: busy=%b valid=%b, required 0 0", post_busy, post_valid);
    end
    checks++;
    if (done_cnt != 0) begin failures++; $display("FAIL abort_done: %0d done pulses, required 0", done_cnt); end
    checks++;
    if (seq_diff(got, head) != 0) begin failures++; $display("FAIL abort_prefix: %0d differences, required 0", seq_diff(got, head)); end
    run(3'd2, 0, -1, -1);
    checks++;
    if (seq_diff(got, exp_q) != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL abort_restart: %0d samples, %0d differences, done %0d, required 240, 0, 1", got.size(), seq_diff(got, exp_q), done_cnt);
    end
  endtask

  task automatic test_repulse_norm();
    logic [2:0] ns [3] = '{3'd0, 3'd3, 3'd7};
    int sizes [3] = '{160, 400, 400};
    for (int t = 0; t < 3; t++) begin
      run(ns[t], 0, -1, 50 + 37 * t);
      build_exp(ns[t]);
      checks++;
      if (got.size() != sizes[t] || seq_diff(got, exp_q) != 0 || done_cnt != 1) begin
        failures++;
        $display("FAIL repulse n=%0d: %0d samples with %0d differences, done %0d, required %0d, 0, 1", ns[t], got.size(), seq_diff(got, exp_q), done_cnt, sizes[t]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    num_ltf = 3'd4; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (120) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ltf_addr === 6'd0 && stf_addr === 4'd0 && out_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_precondition: busy=%b valid=%b, required 1 1", busy, out_valid);
    end
    #3 phy_tx_arestn = 1'b0;
    #1;
    checks++;
    if ({out_iq, out_valid, out_last, busy, done, stf_addr, ltf_addr} !== '0) begin
      failures++;
      $display("FAIL arst_outputs: iq=%h valid=%b last=%b busy=%b done=%b sa=%h la=%h, required all 0",
               out_iq, out_valid, out_last, busy, done, stf_addr, ltf_addr);
    end
    @(negedge clk);
    phy_tx_arestn = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy, out_valid, done} !== 3'b000) begin
      failures++;
      $display("FAIL arst_idle: busy=%b valid=%b done=%b, required 0 0 0", busy, out_valid, done);
    end
    run(3'd1, 0, -1, -1);
    build_exp(3'd1);
    checks++;
    if (seq_diff(got, exp_q) != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL arst_restart: %0d samples, %0d differences, done %0d, required 160, 0, 1", got.size(), seq_diff(got, exp_q), done_cnt);
    end
  endtask

  initial begin
    stf_rom[0] = 32'h061C061C;
    stf_rom[1] = 32'hEE680050;
    for (int i = 2; i < 16; i++) stf_rom[i] = $urandom;
    for (int i = 0; i < 64; i++) ltf_rom[i] = {i[7:0], 24'($urandom)};
    test_reset();
    test_single_ltf();
    test_multi_ltf();
    test_stall();
    test_abort();
    test_repulse_norm();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ht_preamble_seq.md
Name: ht_preamble_seq

Overview:
- Sequences the HT-mixed-format HT-STF and HT-LTF preamble fields into the TX sample stream.
- Drives the address of the 16-entry combinational HT-STF ROM and the 64-entry combinational HT-LTF ROM, and registers the returned samples.
- Emits samples on a valid/ready stream toward the TX sample mux.
- Started by the TX controller after L-SIG; reports done when the last HT-LTF sample has been accepted.

Parameters:
- STF_REPS, 5, number of 16-sample HT-STF periods (80 samples, 4 us at 20 MHz).
- LTF_CP_LEN, 16, cyclic-prefix length per HT-LTF symbol.
- LTF_LEN, 64, HT-LTF body length (ROM depth).

Ports:
- clk  in  1  system clock.
- phy_tx_arestn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; honoured only in IDLE.
- abort  in  1  synchronous abort; forces IDLE next cycle from any state.
- num_ltf  in  3  HT-LTF symbol count: legal values 1, 2, 4; 0 is treated as 1; 3 is treated as 4; values above 4 saturate to 4.
- stf_addr  out  4  HT-STF ROM address.
- stf_dout  in  32  HT-STF ROM sample {I[31:16], Q[15:0]}, combinational from stf_addr.
- ltf_addr  out  6  HT-LTF ROM address.
- ltf_dout  in  32  HT-LTF ROM sample, combinational from ltf_addr.
- out_iq  out  32  registered sample.
- out_valid  out  1  out_iq holds a valid sample.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_last  out  1  high with the final HT-LTF sample.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse, registered, in the cycle after the last sample is accepted.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- Advance condition adv = !out_valid || out_ready. The output register loads only on adv, so ROM addresses are held stable while the stream is stalled. No sample is ever dropped or duplicated.
- States:
  - IDLE: start, when abort is low, moves to STF, clears the sample counter cnt and the symbol counter sym, and latches the normalised num_ltf into nltf. busy rises the next cycle.
  - STF: stf_addr = cnt[3:0]. On adv, out_iq <= stf_dout, out_valid <= 1, cnt++. After the sample with cnt = 16*STF_REPS-1 is loaded: go to LTF_CP and clear cnt.
  - LTF_CP: ltf_addr = LTF_LEN-LTF_CP_LEN+cnt (48..63). After 16 loads: go to LTF and clear cnt.
  - LTF: ltf_addr = cnt (0..63). After 64 loads: if sym == nltf-1, go to DRAIN with out_last set on that sample; else sym++ and go to LTF_CP.
  - DRAIN: no new loads. When the out_last sample is accepted (out_valid && out_ready), clear out_valid and out_last, pulse done, and go to IDLE.
- In the load cycle that leaves a state, out_valid stays 1 if the downstream accepted; there are no bubbles between fields.
- Latency: first sample is valid the cycle after start, given out_ready = 1.
- Throughput: one sample per cycle with out_ready held high. Total samples = 80 + 80*nltf (160/240/400).
- stf_addr and ltf_addr are 0 outside their owning states.
- abort: in the next cycle state = IDLE, out_valid = 0, out_last = 0, no done pulse, counters cleared. abort overrides a coincident start.
- start while busy is ignored.
- Asserting phy_tx_arestn low mid-sequence returns everything to reset values immediately.

Decomposition:
- Shared package (openofdm_tx_pre_def): state encoding localparams (IDLE, STF, LTF_CP, LTF, DRAIN) and constants STF_PERIOD = 16, LTF_ROM_DEPTH = 64.
- One natural sub-module: ht_preamble_outreg, a 32-bit valid/ready holding register with a last flag.
- The ROMs stay external and are instantiated by the parent.

Test Plan:
- Single LTF, out_ready = 1, start at t0:
  - out_valid rises at t0+1.
  - Samples 0 and 1 equal 32'h061C061C and 32'hEE680050.
  - Sample 16 equals sample 0.
  - Sample 80 equals LTF ROM[48]; sample 96 equals LTF ROM[0].
  - out_last on sample 159; done one cycle after its acceptance.
- num_ltf = 2 and num_ltf = 4: exactly 240 and 400 accepted samples. Each LTF symbol is ROM[48..63] followed by ROM[0..63]. out_last only on the final sample.
- Random out_ready stalls at ~40%: the accepted sequence is identical to the no-stall run. out_iq and the addresses stay constant across every stalled cycle.
- abort at sample 100 of num_ltf = 2: next cycle busy = 0, out_valid = 0, no done. A fresh start then reproduces the full sequence from sample 0.
- start re-pulsed mid-sequence, and num_ltf = 0/3/7: the re-pulse is ignored. Sample counts are 160, 400 and 400.
- phy_tx_arestn asserted mid-LTF: all outputs 0 asynchronously. After release, state is IDLE and the block waits for start.
